// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with multi-word lines, round-robin replacement and flush.
// Hits are combinational; a miss issues word requests from T+1, held until each mc_to_ic_ready pulse.
module icache_assoc #(
    parameter int RAM_ADDR_WIDTH = 18,
    parameter int SET_WIDTH      = 6,
    parameter int WAY_WIDTH      = 1,
    parameter int LINE_WIDTH     = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        iu_to_ic_valid,
    input  logic [31:0] iu_to_ic_pc,
    output logic        ic_to_iu_ready,
    output logic [31:0] ic_to_iu_inst,
    output logic        ic_to_mc_valid,
    output logic [31:0] ic_to_mc_addr,
    input  logic        mc_to_ic_ready,
    input  logic [31:0] mc_to_ic_data
);

    localparam int WAYS  = 1 << WAY_WIDTH;
    localparam int SETS  = 1 << SET_WIDTH;
    localparam int WORDS = 1 << LINE_WIDTH;
    localparam int TAG_W = RAM_ADDR_WIDTH - SET_WIDTH - LINE_WIDTH - 2;
    localparam int VW    = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;
    localparam int LW    = (LINE_WIDTH > 0) ? LINE_WIDTH : 1;
    localparam int TV_W  = WAY_WIDTH + SET_WIDTH;
    localparam int DA_W  = TV_W + LINE_WIDTH;

    localparam logic [LW-1:0] LAST_BEAT = LW'(WORDS - 1);
    localparam logic [VW-1:0] LAST_WAY  = VW'(WAYS - 1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [SET_WIDTH-1:0] set;
        logic [VW-1:0]        way;
    } refill_t;

    state_t               state_q;
    state_t               state_d;
    refill_t              req_q;
    logic [LW-1:0]        beat_q;
    logic [WAYS*SETS-1:0] valid_q;
    logic [VW-1:0]        victim_q [SETS];
    logic [TAG_W-1:0]     tag_mem  [WAYS*SETS];
    logic [31:0]          data_mem [WAYS*SETS*WORDS];

    logic [TAG_W-1:0]     pc_tag;
    logic [SET_WIDTH-1:0] pc_set;
    logic [LW-1:0]        pc_off;
    logic [31:0]          pc_base;
    logic                 unused_pc_bits;

    logic                 hit;
    logic [31:0]          hit_inst;
    logic                 start_refill;
    logic                 beat_acc;
    logic                 line_done;
    logic                 abort;
    logic [VW-1:0]        next_victim;

    assign pc_tag         = iu_to_ic_pc[RAM_ADDR_WIDTH-1:SET_WIDTH+LINE_WIDTH+2];
    assign pc_set         = iu_to_ic_pc[SET_WIDTH+LINE_WIDTH+1:LINE_WIDTH+2];
    assign pc_base        = {iu_to_ic_pc[31:LINE_WIDTH+2], {(LINE_WIDTH+2){1'b0}}};
    assign unused_pc_bits = ^iu_to_ic_pc[1:0];

    generate
        if (LINE_WIDTH > 0) begin : g_off
            assign pc_off = iu_to_ic_pc[LINE_WIDTH+1:2];
        end else begin : g_no_off
            assign pc_off = '0;
        end
    endgenerate

    // Flat array indices: {way, set} for tag/valid, {way, set, word} for data.
    function automatic logic [TV_W-1:0] tv_idx(input logic [VW-1:0] w,
                                               input logic [SET_WIDTH-1:0] s);
        return (TV_W'(w) << SET_WIDTH) | TV_W'(s);
    endfunction

    function automatic logic [DA_W-1:0] da_idx(input logic [VW-1:0] w,
                                               input logic [SET_WIDTH-1:0] s,
                                               input logic [LW-1:0] o);
        return (DA_W'(w) << (SET_WIDTH + LINE_WIDTH)) | (DA_W'(s) << LINE_WIDTH)
             | DA_W'(o & LAST_BEAT);
    endfunction

    always_comb begin
        hit      = 1'b0;
        hit_inst = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (iu_to_ic_valid && valid_q[tv_idx(VW'(w), pc_set)]
                && tag_mem[tv_idx(VW'(w), pc_set)] == pc_tag) begin
                hit      = 1'b1;
                hit_inst = data_mem[da_idx(VW'(w), pc_set, pc_off)];
            end
        end
    end

    assign ic_to_iu_ready = hit && (state_q == IDLE) && !flush_in;
    assign ic_to_iu_inst  = hit_inst;
    assign next_victim    = (req_q.way == LAST_WAY) ? '0 : req_q.way + VW'(1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush outranks a returning beat, including the final one.
    always_comb begin
        state_d      = state_q;
        start_refill = 1'b0;
        beat_acc     = 1'b0;
        line_done    = 1'b0;
        abort        = 1'b0;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (iu_to_ic_valid && !hit && !flush_in) begin
                        start_refill = 1'b1;
                        state_d      = REFILL;
                    end
                end
                REFILL: begin
                    if (flush_in) begin
                        abort   = 1'b1;
                        state_d = IDLE;
                    end else if (mc_to_ic_ready) begin
                        beat_acc = 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            line_done = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ic_to_mc_valid <= 1'b0;
            ic_to_mc_addr  <= '0;
            beat_q         <= '0;
            req_q          <= '0;
        end else begin
            if (start_refill) begin
                req_q          <= '{tag: pc_tag, set: pc_set, way: victim_q[pc_set]};
                beat_q         <= '0;
                ic_to_mc_valid <= 1'b1;
                ic_to_mc_addr  <= pc_base;
            end
            if (beat_acc) begin
                beat_q        <= beat_q + LW'(1);
                ic_to_mc_addr <= ic_to_mc_addr + 32'd4;
            end
            if (line_done || abort) begin
                ic_to_mc_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                victim_q[s] <= '0;
            end
        end else begin
            if (rdy_in && flush_in) begin
                valid_q <= '0;
            end
            if (line_done) begin
                valid_q[tv_idx(req_q.way, req_q.set)] <= 1'b1;
                victim_q[req_q.set]                  <= next_victim;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk_in) begin
        if (beat_acc) begin
            data_mem[da_idx(req_q.way, req_q.set, beat_q)] <= mc_to_ic_data;
        end
        if (line_done) begin
            tag_mem[tv_idx(req_q.way, req_q.set)] <= req_q.tag;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: default 2-way/4-word build plus a direct-mapped single-word build.
module tb_icache_assoc;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        iu_valid [2];
    logic [31:0] iu_pc    [2];
    logic        ic_ready [2];
    logic [31:0] ic_inst  [2];
    logic        mc_valid [2];
    logic [31:0] mc_addr  [2];
    logic        mc_ready [2];
    logic [31:0] mc_data  [2];

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    icache_assoc dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .iu_to_ic_valid(iu_valid[0]), .iu_to_ic_pc(iu_pc[0]),
        .ic_to_iu_ready(ic_ready[0]), .ic_to_iu_inst(ic_inst[0]),
        .ic_to_mc_valid(mc_valid[0]), .ic_to_mc_addr(mc_addr[0]),
        .mc_to_ic_ready(mc_ready[0]), .mc_to_ic_data(mc_data[0])
    );

    icache_assoc #(.RAM_ADDR_WIDTH(18), .SET_WIDTH(6), .WAY_WIDTH(0), .LINE_WIDTH(0)) dut_dm (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .iu_to_ic_valid(iu_valid[1]), .iu_to_ic_pc(iu_pc[1]),
        .ic_to_iu_ready(ic_ready[1]), .ic_to_iu_inst(ic_inst[1]),
        .ic_to_mc_valid(mc_valid[1]), .ic_to_mc_addr(mc_addr[1]),
        .mc_to_ic_ready(mc_ready[1]), .mc_to_ic_data(mc_data[1])
    );

    typedef struct {
        logic [31:0] pc;
        bit          miss;
        logic [31:0] inst;
    } vec_t;

    vec_t vt[14];
    vec_t dv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Services beats [first, upto) of a refill; each request is checked, held a cycle, then answered.
    task automatic serve(input int d, input logic [31:0] base, input int first, input int upto);
        for (int b = first; b < upto; b++) begin
            #1;
            chk("req_vld", {31'd0, mc_valid[d]}, 32'd1);
            chk("req_addr", mc_addr[d], base + 32'(4 * b));
            tick();
            #1;
            chk("req_hold", mc_addr[d], base + 32'(4 * b));
            mc_ready[d] = 1'b1;
            mc_data[d]  = base + 32'(4 * b) + 32'hA000;
            tick();
            mc_ready[d] = 1'b0;
        end
    endtask

    task automatic fetch(input int d, input logic [31:0] p, input bit miss,
                         input logic [31:0] exp, input int words);
        iu_valid[d] = 1'b1;
        iu_pc[d]    = p;
        #1;
        if (miss) begin
            chk("miss_rdy", {31'd0, ic_ready[d]}, 32'd0);
            tick();
            serve(d, p & ~(32'(words * 4) - 32'd1), 0, words);
            #1;
        end
        chk("hit_rdy", {31'd0, ic_ready[d]}, 32'd1);
        chk("inst", ic_inst[d], exp);
        tick();
        iu_valid[d] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{32'h0000_0000, 1'b1, 32'h0000_A000};
        vt[1]  = '{32'h0000_0400, 1'b1, 32'h0000_A400};
        vt[2]  = '{32'h0000_0004, 1'b0, 32'h0000_A004};
        vt[3]  = '{32'h0000_0800, 1'b1, 32'h0000_A800};
        vt[4]  = '{32'h0000_0404, 1'b0, 32'h0000_A404};
        vt[5]  = '{32'h0000_0000, 1'b1, 32'h0000_A000};
        vt[6]  = '{32'h0000_0808, 1'b0, 32'h0000_A808};
        vt[7]  = '{32'h0000_1004, 1'b1, 32'h0000_B004};
        vt[8]  = '{32'h0000_100C, 1'b0, 32'h0000_B00C};
        vt[9]  = '{32'h0000_000C, 1'b0, 32'h0000_A00C};
        vt[10] = '{32'h0000_0800, 1'b1, 32'h0000_A800};
        vt[11] = '{32'h0000_1008, 1'b0, 32'h0000_B008};
        vt[12] = '{32'h0000_0014, 1'b1, 32'h0000_A014};
        vt[13] = '{32'h0000_001C, 1'b0, 32'h0000_A01C};

        dv[0] = '{32'h0000_0000, 1'b1, 32'h0000_A000};
        dv[1] = '{32'h0000_0000, 1'b0, 32'h0000_A000};
        dv[2] = '{32'h0000_0100, 1'b1, 32'h0000_A100};
        dv[3] = '{32'h0000_0000, 1'b1, 32'h0000_A000};
        dv[4] = '{32'h0000_0100, 1'b1, 32'h0000_A100};
        dv[5] = '{32'h0000_0104, 1'b1, 32'h0000_A104};
        dv[6] = '{32'h0000_0100, 1'b0, 32'h0000_A100};

        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iu_valid[d] = 1'b0;
            iu_pc[d]    = '0;
            mc_ready[d] = 1'b0;
            mc_data[d]  = '0;
        end
        iu_valid[0] = 1'b1;
        repeat (2) tick();
        #1;
        chk("rst_rdy", {31'd0, ic_ready[0]}, 32'd0);
        chk("rst_mc_vld", {31'd0, mc_valid[0]}, 32'd0);
        chk("rst_mc_addr", mc_addr[0], 32'd0);
        iu_valid[0] = 1'b0;
        rst_in = 1'b0;
        tick();

        // Fill/conflict/round-robin sequence on set 0 and set 1.
        for (int i = 0; i < 14; i++) begin
            fetch(0, vt[i].pc, vt[i].miss, vt[i].inst, 4);
        end

        // Flush while idle with 0x1000 resident.
        iu_valid[0] = 1'b1;
        iu_pc[0]    = 32'h1000;
        #1;
        chk("pre_flush_hit", {31'd0, ic_ready[0]}, 32'd1);
        flush_in = 1'b1;
        #1;
        chk("flush_cycle_rdy", {31'd0, ic_ready[0]}, 32'd0);
        tick();
        flush_in = 1'b0;
        #1;
        chk("flush_no_req", {31'd0, mc_valid[0]}, 32'd0);
        iu_valid[0] = 1'b0;
        tick();
        fetch(0, 32'h1000, 1'b1, 32'hB000, 4);

        // Abort a refill after three beats, then a late return while idle.
        iu_valid[0] = 1'b1;
        iu_pc[0]    = 32'h2000;
        #1;
        tick();
        serve(0, 32'h2000, 0, 3);
        flush_in = 1'b1;
        tick();
        flush_in    = 1'b0;
        iu_valid[0] = 1'b0;
        #1;
        chk("abort_vld", {31'd0, mc_valid[0]}, 32'd0);
        mc_ready[0] = 1'b1;
        mc_data[0]  = 32'hDEAD_BEEF;
        tick();
        mc_ready[0] = 1'b0;
        #1;
        chk("late_ret_vld", {31'd0, mc_valid[0]}, 32'd0);
        tick();
        fetch(0, 32'h2000, 1'b1, 32'hC000, 4);

        // Flush landing on the final beat leaves the line invalid.
        iu_valid[0] = 1'b1;
        iu_pc[0]    = 32'h3000;
        #1;
        tick();
        serve(0, 32'h3000, 0, 3);
        #1;
        chk("last_req_addr", mc_addr[0], 32'h300C);
        mc_ready[0] = 1'b1;
        mc_data[0]  = 32'hD00C;
        flush_in    = 1'b1;
        tick();
        mc_ready[0] = 1'b0;
        flush_in    = 1'b0;
        #1;
        chk("flush_last_rdy", {31'd0, ic_ready[0]}, 32'd0);
        chk("flush_last_vld", {31'd0, mc_valid[0]}, 32'd0);
        iu_valid[0] = 1'b0;
        tick();

        // rdy_in low for five cycles while the memory keeps pulsing.
        iu_valid[0] = 1'b1;
        iu_pc[0]    = 32'h3000;
        #1;
        tick();
        serve(0, 32'h3000, 0, 1);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mc_ready[0] = 1'b1;
            mc_data[0]  = 32'hDEAD_BEEF;
            #1;
            chk("stall_addr", mc_addr[0], 32'h3004);
            chk("stall_vld", {31'd0, mc_valid[0]}, 32'd1);
            tick();
        end
        mc_ready[0] = 1'b0;
        rdy_in      = 1'b1;
        serve(0, 32'h3000, 1, 4);
        #1;
        chk("stall_hit_rdy", {31'd0, ic_ready[0]}, 32'd1);
        chk("stall_inst0", ic_inst[0], 32'hD000);
        iu_pc[0] = 32'h3004;
        #1;
        chk("stall_inst1", ic_inst[0], 32'hD004);
        iu_valid[0] = 1'b0;
        tick();

        // Asynchronous reset between edges during a refill.
        iu_valid[0] = 1'b1;
        iu_pc[0]    = 32'h4010;
        #1;
        tick();
        #1;
        chk("pre_rst_vld", {31'd0, mc_valid[0]}, 32'd1);
        rst_in = 1'b1;
        #1;
        chk("async_rst_vld", {31'd0, mc_valid[0]}, 32'd0);
        chk("async_rst_addr", mc_addr[0], 32'd0);
        iu_valid[0] = 1'b0;
        #1;
        rst_in = 1'b0;
        tick();
        fetch(0, 32'h3000, 1'b1, 32'hD000, 4);

        // Direct-mapped, single-word build.
        for (int i = 0; i < 7; i++) begin
            fetch(1, dv[i].pc, dv[i].miss, dv[i].inst, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
